// File: rtl/lane_cfg_ctrl.sv
// lane_cfg_ctrl: sequences run-time changes of the dispatch-lane active mask.
// A request freezes the front end, waits for the pipeline to drain, then
// raises power-enables, waits SETTLE_CYCLES, switches clock-enables, waits
// SETTLE_CYCLES again and finally drops power on lanes that were disabled.
// laneActive_o is kept a subset of lanePwr_o on every cycle.
//
// Optional feature: define LANE_CFG_TIMEOUT_EN to abort a request whose
// drain phase exceeds DRAIN_TIMEOUT cycles (cfgErr_o pulse, masks untouched).
module lane_cfg_ctrl #(
  parameter int unsigned DISPATCH_WIDTH = 4,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned DRAIN_TIMEOUT  = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfgReq_i,
  input  logic [DISPATCH_WIDTH-1:0] cfgMask_i,
  input  logic                      pipeEmpty_i,
  output logic                      stall_o,
  output logic [DISPATCH_WIDTH-1:0] lanePwr_o,
  output logic [DISPATCH_WIDTH-1:0] laneActive_o,
  output logic                      cfgBusy_o,
  output logic                      cfgDone_o,
  output logic                      cfgErr_o
);

  localparam int unsigned SETTLE_W = 4;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  // Reject out-of-range parameterisations at elaboration.
  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
    $error("lane_cfg_ctrl: SETTLE_CYCLES must be in 1..15");
  end
  if (DRAIN_TIMEOUT < 1) begin : g_bad_timeout
    $error("lane_cfg_ctrl: DRAIN_TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_PWRUP,
    S_SETTLE_UP,
    S_SETTLE_DN,
    S_DONE
  } state_e;

  state_e                      state_q;
  logic [DISPATCH_WIDTH-1:0]   target_q;
  logic [DISPATCH_WIDTH-1:0]   pwr_q;
  logic [DISPATCH_WIDTH-1:0]   act_q;
  logic [SETTLE_W-1:0]         settle_q;
  logic                        stall_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        err_q;

`ifdef LANE_CFG_TIMEOUT_EN
  localparam int unsigned DRAIN_CNT_W = $clog2(DRAIN_TIMEOUT) + 1;
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_TIMEOUT - 1);
  logic [DRAIN_CNT_W-1:0] drainCnt_q;
`endif

  logic                      maskInvalid_d;
  logic [DISPATCH_WIDTH-1:0] pwrUp_d;

  // Request qualification and the power-up mask (union of old and new lanes).
  always_comb begin
    maskInvalid_d = (cfgMask_i[0] == 1'b0) || (cfgMask_i == '0);
    pwrUp_d       = pwr_q | target_q;
  end

  // Reconfiguration sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      target_q   <= '1;
      pwr_q      <= '1;
      act_q      <= '1;
      settle_q   <= '0;
      stall_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LANE_CFG_TIMEOUT_EN
      drainCnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfgReq_i) begin
            if (maskInvalid_d) begin
              err_q <= 1'b1;
            end else if (cfgMask_i == act_q) begin
              done_q <= 1'b1;
            end else begin
              target_q <= cfgMask_i;
              stall_q  <= 1'b1;
              busy_q   <= 1'b1;
              state_q  <= S_DRAIN;
`ifdef LANE_CFG_TIMEOUT_EN
              drainCnt_q <= '0;
`endif
            end
          end
        end
        S_DRAIN: begin
          if (pipeEmpty_i) begin
            state_q <= S_PWRUP;
`ifdef LANE_CFG_TIMEOUT_EN
          end else if (drainCnt_q == DRAIN_LAST) begin
            err_q   <= 1'b1;
            stall_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            drainCnt_q <= drainCnt_q + 1'b1;
`endif
          end
        end
        S_PWRUP: begin
          pwr_q    <= pwrUp_d;
          settle_q <= SETTLE_LOAD;
          state_q  <= S_SETTLE_UP;
        end
        S_SETTLE_UP: begin
          if (settle_q == '0) begin
            act_q    <= target_q;
            settle_q <= SETTLE_LOAD;
            state_q  <= S_SETTLE_DN;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        S_SETTLE_DN: begin
          if (settle_q == '0) begin
            pwr_q   <= target_q;
            done_q  <= 1'b1;
            stall_q <= 1'b0;
            state_q <= S_DONE;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          stall_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign stall_o      = stall_q;
  assign lanePwr_o    = pwr_q;
  assign laneActive_o = act_q;
  assign cfgBusy_o    = busy_q;
  assign cfgDone_o    = done_q;
  assign cfgErr_o     = err_q;

endmodule

// File: tb/tb_lane_cfg_ctrl.sv
// Testbench for lane_cfg_ctrl: fixed vector table, directed corner sequences
// and randomized traffic checked against a timeline-based reference model.
module tb_lane_cfg_ctrl;

  localparam int W = 4;
  localparam int S = 4;
  localparam int T = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cfgReq = 1'b0;
  logic [W-1:0] cfgMask = '0;
  logic         pipeEmpty = 1'b0;
  logic         stall_o, cfgBusy_o, cfgDone_o, cfgErr_o;
  logic [W-1:0] lanePwr_o, laneActive_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lane_cfg_ctrl #(
    .DISPATCH_WIDTH(W),
    .SETTLE_CYCLES (S),
    .DRAIN_TIMEOUT (T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfgReq_i    (cfgReq),
    .cfgMask_i   (cfgMask),
    .pipeEmpty_i (pipeEmpty),
    .stall_o     (stall_o),
    .lanePwr_o   (lanePwr_o),
    .laneActive_o(laneActive_o),
    .cfgBusy_o   (cfgBusy_o),
    .cfgDone_o   (cfgDone_o),
    .cfgErr_o    (cfgErr_o)
  );

  // Reference model: tracks the edge at which the drain completed and
  // derives every output change from its distance to that edge.
  logic [W-1:0] m_pwr = '1, m_act = '1, m_tgt = '1;
  logic         m_stall = 0, m_busy = 0, m_done = 0, m_err = 0, m_draining = 0;
  int           m_edge = 0, m_emptyEdge = 0, m_drainCnt = 0;

  task automatic model_edge();
    int rel;
    m_edge++;
    m_done = 0;
    m_err  = 0;
    if (reset) begin
      m_pwr = '1; m_act = '1; m_tgt = '1;
      m_stall = 0; m_busy = 0; m_draining = 0;
    end else if (!m_busy) begin
      if (cfgReq) begin
        if (cfgMask[0] == 1'b0) m_err = 1;
        else if (cfgMask == m_act) m_done = 1;
        else begin
          m_tgt = cfgMask; m_busy = 1; m_stall = 1;
          m_draining = 1; m_drainCnt = 0;
        end
      end
    end else if (m_draining) begin
      if (pipeEmpty) begin
        m_draining = 0;
        m_emptyEdge = m_edge;
      end
`ifdef LANE_CFG_TIMEOUT_EN
      else begin
        m_drainCnt++;
        if (m_drainCnt == T) begin
          m_err = 1; m_stall = 0; m_busy = 0; m_draining = 0;
        end
      end
`endif
    end else begin
      rel = m_edge - m_emptyEdge;
      if (rel == 1)         m_pwr = m_pwr | m_tgt;
      if (rel == 1 + S)     m_act = m_tgt;
      if (rel == 1 + 2 * S) begin m_pwr = m_tgt; m_done = 1; m_stall = 0; end
      if (rel == 2 + 2 * S) m_busy = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: advance model, then compare every output and the invariants.
  task automatic step();
    logic [W-1:0] pp, pa;
    logic         ps, pr;
    pp = lanePwr_o; pa = laneActive_o; ps = stall_o; pr = reset;
    @(posedge clk);
    model_edge();
    #1;
    chk("lanePwr", lanePwr_o, m_pwr);
    chk("laneActive", laneActive_o, m_act);
    chk("stall", stall_o, m_stall);
    chk("busy", cfgBusy_o, m_busy);
    chk("done", cfgDone_o, m_done);
    chk("err", cfgErr_o, m_err);
    chk("subset", laneActive_o & ~lanePwr_o, 0);
    if (!pr && !ps) begin
      chk("frozen_pwr", lanePwr_o, pp);
      chk("frozen_act", laneActive_o, pa);
    end
  endtask

  task automatic apply(input logic r, input logic q, input logic [W-1:0] m, input logic e);
    reset = r; cfgReq = q; cfgMask = m; pipeEmpty = e;
    step();
  endtask

  // Complete one reconfiguration with an always-empty pipeline.
  task automatic run_cfg(input logic [W-1:0] m);
    apply(0, 1, m, 1);
    cfgReq = 0;
    for (int i = 0; i < 40 && cfgBusy_o; i++) step();
    chk("run_cfg_idle", cfgBusy_o, 0);
  endtask

  typedef struct {
    logic         rst, req;
    logic [W-1:0] mask;
    logic         empty;
    logic [W-1:0] pwr, act;
    logic         stall, busy, done, err;
  } vec_t;

  function automatic vec_t v(logic r, logic q, logic [W-1:0] m, logic e,
                             logic [W-1:0] p, logic [W-1:0] a,
                             logic s, logic b, logic d, logic x);
    vec_t t;
    t.rst = r; t.req = q; t.mask = m; t.empty = e;
    t.pwr = p; t.act = a; t.stall = s; t.busy = b; t.done = d; t.err = x;
    return t;
  endfunction

  vec_t tbl[30];
  int   doneCnt;

  initial begin
    // 0..12: reset, then 1111 -> 0011
    tbl[0]  = v(1, 0, 4'h0, 1, 4'hF, 4'hF, 0, 0, 0, 0);
    tbl[1]  = v(0, 1, 4'h3, 1, 4'hF, 4'hF, 1, 1, 0, 0);
    for (int i = 2; i <= 6; i++)  tbl[i] = v(0, 0, 4'h0, 1, 4'hF, 4'hF, 1, 1, 0, 0);
    for (int i = 7; i <= 10; i++) tbl[i] = v(0, 0, 4'h0, 1, 4'hF, 4'h3, 1, 1, 0, 0);
    tbl[11] = v(0, 0, 4'h0, 1, 4'h3, 4'h3, 0, 1, 1, 0);
    tbl[12] = v(0, 0, 4'h0, 1, 4'h3, 4'h3, 0, 0, 0, 0);
    // 13..24: 0011 -> 1111, power rises 4 cycles before clock-enable
    tbl[13] = v(0, 1, 4'hF, 1, 4'h3, 4'h3, 1, 1, 0, 0);
    tbl[14] = v(0, 0, 4'h0, 1, 4'h3, 4'h3, 1, 1, 0, 0);
    for (int i = 15; i <= 18; i++) tbl[i] = v(0, 0, 4'h0, 1, 4'hF, 4'h3, 1, 1, 0, 0);
    for (int i = 19; i <= 22; i++) tbl[i] = v(0, 0, 4'h0, 1, 4'hF, 4'hF, 1, 1, 0, 0);
    tbl[23] = v(0, 0, 4'h0, 1, 4'hF, 4'hF, 0, 1, 1, 0);
    tbl[24] = v(0, 0, 4'h0, 1, 4'hF, 4'hF, 0, 0, 0, 0);
    // 25..29: rejected masks, then same-mask request
    tbl[25] = v(0, 1, 4'hE, 1, 4'hF, 4'hF, 0, 0, 0, 1);
    tbl[26] = v(0, 1, 4'h0, 1, 4'hF, 4'hF, 0, 0, 0, 1);
    tbl[27] = v(0, 0, 4'h0, 1, 4'hF, 4'hF, 0, 0, 0, 0);
    tbl[28] = v(0, 1, 4'hF, 1, 4'hF, 4'hF, 0, 0, 1, 0);
    tbl[29] = v(0, 0, 4'h0, 1, 4'hF, 4'hF, 0, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      apply(tbl[i].rst, tbl[i].req, tbl[i].mask, tbl[i].empty);
      chk($sformatf("tbl%0d_pwr", i), lanePwr_o, tbl[i].pwr);
      chk($sformatf("tbl%0d_act", i), laneActive_o, tbl[i].act);
      chk($sformatf("tbl%0d_stall", i), stall_o, tbl[i].stall);
      chk($sformatf("tbl%0d_busy", i), cfgBusy_o, tbl[i].busy);
      chk($sformatf("tbl%0d_done", i), cfgDone_o, tbl[i].done);
      chk($sformatf("tbl%0d_err", i), cfgErr_o, tbl[i].err);
    end

    // Long drain to 0001 with a second request ignored during DRAIN.
    apply(0, 1, 4'h1, 0);
    for (int i = 0; i < 10; i++) begin
      apply(0, (i == 3), 4'h3, 0);
      chk("drain_stall", stall_o, 1);
      chk("drain_pwr", lanePwr_o, 4'hF);
    end
    doneCnt = 0;
    apply(0, 0, 4'h0, 1);
    for (int i = 0; i < 40 && cfgBusy_o; i++) begin
      apply(0, 0, 4'h0, 1'($urandom_range(0, 1)));
      if (cfgDone_o) doneCnt++;
    end
    chk("drain_done_cnt", doneCnt, 1);
    chk("drain_final_pwr", lanePwr_o, 4'h1);
    chk("drain_final_act", laneActive_o, 4'h1);

    // Request arriving on the DONE cycle is ignored.
    apply(0, 1, 4'hF, 1);
    cfgReq = 0;
    for (int i = 0; i < 40 && !cfgDone_o; i++) step();
    chk("done_seen", cfgDone_o, 1);
    apply(0, 1, 4'h3, 1);
    chk("done_req_busy", cfgBusy_o, 0);
    chk("done_req_stall", stall_o, 0);
    apply(0, 0, 4'h0, 1);
    chk("done_req_act", laneActive_o, 4'hF);

    // Reset in SETTLE_UP while 0011 -> 0111 is in flight.
    run_cfg(4'h3);
    apply(0, 1, 4'h7, 1);
    apply(0, 0, 4'h0, 1);
    apply(0, 0, 4'h0, 1);
    apply(0, 0, 4'h0, 1);
    chk("su_pwr", lanePwr_o, 4'h7);
    chk("su_act", laneActive_o, 4'h3);
    apply(1, 0, 4'h0, 1);
    chk("rst_pwr", lanePwr_o, 4'hF);
    chk("rst_act", laneActive_o, 4'hF);
    chk("rst_stall", stall_o, 0);
    chk("rst_busy", cfgBusy_o, 0);

`ifdef LANE_CFG_TIMEOUT_EN
    // Drain never completes: abort after T cycles in DRAIN.
    apply(0, 1, 4'h3, 0);
    for (int i = 1; i <= T; i++) begin
      apply(0, 0, 4'h0, 0);
      if (i < T) chk("to_wait_err", cfgErr_o, 0);
    end
    chk("to_err", cfgErr_o, 1);
    chk("to_stall", stall_o, 0);
    chk("to_pwr", lanePwr_o, 4'hF);
    chk("to_act", laneActive_o, 4'hF);
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] m;
      m = W'($urandom);
      if ($urandom_range(0, 3) != 0) m[0] = 1'b1;
      apply(($urandom_range(0, 299) == 0), ($urandom_range(0, 5) == 0), m,
            ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
